// File: rtl/decryption_inv_sub_bytes.sv
// decryption_inv_sub_bytes: AES InvSubBytes engine, LANES bytes per cycle over a 128-bit state.
// Optional DEC_INV_SHIFT_ROWS_EN adds an InvShiftRows wiring permutation on out_data.
module decryption_inv_sub_bytes #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad
    $error("LANES must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  state_t state, state_next;
  logic [3:0] cnt;
  logic [127:0] work, sub;
  logic last;
  assign last = cnt == 4'(16 - LANES);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_next = state == IDLE ? (in_valid ? BUSY : IDLE) :
                 state == BUSY ? (last ? DONE : BUSY) :
                 (out_ready ? IDLE : DONE);
  end
  // The current group of LANES bytes is replaced in place; the rest pass through.
  always_comb begin
    sub = work;
    for (int j = 0; j < LANES; j++)
      sub[127 - 8 * (int'(cnt) + j) -: 8] = inv_sbox[work[127 - 8 * (int'(cnt) + j) -: 8]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      work <= in_data;
      cnt <= '0;
    end else if (state == BUSY) begin
      work <= sub;
      cnt <= last ? 4'd0 : cnt + 4'(LANES);
    end
  end
`ifdef DEC_INV_SHIFT_ROWS_EN
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign out_data[127 - 8 * (4 * c + r) -: 8] = work[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
    end
  end
`else
  assign out_data = work;
`endif
endmodule

// File: tb/tb_decryption_inv_sub_bytes.sv
// tb_decryption_inv_sub_bytes: scoreboard bench for the InvSubBytes engine (LANES=4).
module tb_decryption_inv_sub_bytes;
  localparam int LANES = 4;
  localparam logic [7:0] fwd [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
  logic [127:0] in_data = '0, out_data, held;
  logic [127:0] sb [$];
  int n_tests = 0, n_fail = 0;
  decryption_inv_sub_bytes #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] isr(input logic [127:0] x);
`ifdef DEC_INV_SHIFT_ROWS_EN
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[127 - 8 * k -: 8] = x[127 - 8 * (((k / 4 - k % 4 + 4) % 4) * 4 + k % 4) -: 8];
    return y;
`else
    return x;
`endif
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Monitor: every output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        logic [127:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL output_data: got %h expected %h", out_data, e);
        end
      end
    end
  end
  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk("in_ready_wait", 128'(in_ready), 128'd1);
    in_data = d;
    in_valid = 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
    in_data = 'x;
    chk("busy_after_accept", {126'd0, busy, in_ready}, 128'd2);
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    chk("latency", 128'(w), 128'(16 / LANES));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, busy, out_data}, {3'b100, 128'h0});
    rst_n = 1;
    @(posedge clk); #1;
    send({16{8'h63}}, 128'h0);
    send({16{8'h7c}}, {16{8'h01}});
    send(128'h0063ed16_63636363_63636363_63636363, isr(128'h520053ff_00000000_00000000_00000000));
    send(128'h637c777b_f26b6fc5_3001672b_fed7ab76,
`ifdef DEC_INV_SHIFT_ROWS_EN
         128'h000d0a07_04010e0b_0805020f_0c090603);
`else
         128'h00010203_04050607_08090a0b_0c0d0e0f);
`endif
    send({16{8'h7d}}, {16{8'h13}});
    // Back-pressure: output must hold and a second request must be ignored.
    @(posedge clk); #1;
    out_ready = 0;
    send({16{8'h7c}}, {16{8'h01}});
    held = out_data;
    in_valid = 1;
    in_data = {16{8'h00}};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, busy, out_data}, {3'b101, held});
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", {126'd0, out_valid, in_ready}, 128'd1);
    for (int x = 0; x < 256; x++) send({16{fwd[x]}}, {16{8'(x)}});
    // Reset pulsed in the second BUSY cycle discards the partial state.
    @(posedge clk); #1;
    in_data = {16{8'h63}};
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #2;
    rst_n = 1;
    chk("mid_reset", {in_ready, out_valid, busy, out_data}, {3'b100, 128'h0});
    send({16{8'h16}}, {16{8'hff}});
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
